fir_filter_stream: RTL

//  Parametrised streaming FIR filter, successor to the fixed 6-tap direct/transposed pair in top_FIR_filter.
//  One instance implements either the direct or the transposed form, selected at run time.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_tap_mac.sv | 18 +
 rtl/fir_filter_stream.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants, legacy coefficients and arithmetic helper
// for the streaming FIR filter.
package fir_pkg;

    localparam logic FIR_DIRECT    = 1'b0;
    localparam logic FIR_TRANSPOSE = 1'b1;

    localparam int FIR_TAPS   = 6;
    localparam int FIR_DATA_W = 12;
    localparam int FIR_COEF_W = 14;
    localparam int FIR_ACC_W  = 26;

    localparam logic [13:0] LEGACY_COEF [6] = '{
        14'h3aa4, 14'h1433, 14'h0e37,
        14'h1a57, 14'h0917, 14'h2c1d
    };

    // Operands arrive sign-extended; callers truncate to their ACC_W.
    function automatic logic signed [63:0] mul_ext(
        input logic signed [63:0] c,
        input logic signed [63:0] x
    );
        return c * x;
    endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// One FIR tap: coef * sample plus incoming partial sum,
// wrapped to ACC_W bits.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int ACC_W  = FIR_ACC_W
) (
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic        [ACC_W-1:0]  pin_i,
    output logic        [ACC_W-1:0]  sum_o
);

    assign sum_o = ACC_W'(mul_ext(64'(coef_i), 64'(x_i))) + pin_i;

endmodule

// File: rtl/fir_filter_stream.sv
// Streaming FIR, direct or transposed form chosen at reset
// release / flush, with runtime coefficients and backpressure.
module fir_filter_stream
    import fir_pkg::*;
#(
    parameter int TAPS   = FIR_TAPS,
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int ACC_W  = FIR_ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    flush,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    warm
);

    localparam int CNT_W = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TAPS);

    logic [COEF_W-1:0] coef_q [TAPS];
    logic [DATA_W-1:0] hist_q [1:TAPS-1];
    logic [ACC_W-1:0]  z_q    [1:TAPS-1];
    logic [ACC_W-1:0]  sum_w  [TAPS];
    logic [ACC_W-1:0]  data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              valid_q;
    logic              warm_q;
    logic              mode_q;
    logic              init_q;
    logic              mode_act;
    logic              accept;

    // Before the first edge after reset the live input is the mode.
    assign mode_act  = init_q ? mode_q : mode;
    assign in_ready  = !flush && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign cnt_d     = (cnt_q == FULL) ? cnt_q : cnt_q + CNT_W'(1);
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign warm      = warm_q;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic [DATA_W-1:0] x;
        logic [ACC_W-1:0]  pin;
        logic [ACC_W-1:0]  sum;

        if (k == 0) begin : g_x0
            assign x = in_data;
        end else begin : g_xk
            assign x = (mode_act == FIR_DIRECT) ? hist_q[k] : in_data;
        end

        // Direct: combinational adder chain; transposed: registered z.
        if (k == TAPS - 1) begin : g_end
            assign pin = '0;
        end else begin : g_chain
            assign pin = (mode_act == FIR_DIRECT) ? g_tap[k+1].sum
                                                  : z_q[k+1];
        end

        fir_tap_mac #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .coef_i (coef_q[k]),
            .x_i    (x),
            .pin_i  (pin),
            .sum_o  (sum)
        );

        assign sum_w[k] = sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
            for (int k = 1; k < TAPS; k++) begin
                hist_q[k] <= '0;
                z_q[k]    <= '0;
            end
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            warm_q  <= 1'b0;
            mode_q  <= FIR_DIRECT;
            init_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (!init_q) mode_q <= mode;
            if (coef_we && (32'(coef_addr) < TAPS))
                coef_q[coef_addr] <= coef_data;
            if (flush) begin
                for (int k = 1; k < TAPS; k++) begin
                    hist_q[k] <= '0;
                    z_q[k]    <= '0;
                end
                cnt_q   <= '0;
                warm_q  <= 1'b0;
                valid_q <= 1'b0;
                mode_q  <= mode;
            end else if (accept) begin
                hist_q[1] <= in_data;
                for (int k = 2; k < TAPS; k++) hist_q[k] <= hist_q[k-1];
                for (int k = 1; k < TAPS; k++) z_q[k] <= sum_w[k];
                data_q  <= sum_w[0];
                valid_q <= 1'b1;
                cnt_q   <= cnt_d;
                warm_q  <= (cnt_d == FULL);
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
